// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB2AXI bridge: command directory entries,
// read-data FIFO entries and AXI response codes.
package apb2axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int TAG_NUM    = 1 << AXI_ID_W;
    localparam int OUTS_W     = $clog2(TAG_NUM + 1);

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   tag;
        logic [AXI_ADDR_W-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
    } directory_entry_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   tag;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic                  err;
    } rd_entry_t;

    localparam int CMD_ENTRY_W = $bits(directory_entry_t);
    localparam int RD_ENTRY_W  = $bits(rd_entry_t);

endpackage

// File: rtl/apb2axi_rd_tag_tracker.sv
// Per-tag read burst state: active flag, remaining beats and sticky error.
// Set and beat update are always on different tags because a set needs the tag idle and a beat needs it active.
module apb2axi_rd_tag_tracker
    import apb2axi_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [AXI_ID_W-1:0] set_tag,
    input  logic [3:0]          set_len,
    input  logic                beat_en,
    input  logic [AXI_ID_W-1:0] beat_tag,
    input  logic                beat_bad,
    input  logic                beat_last,
    output logic [TAG_NUM-1:0]  active,
    output logic                beat_hit,
    output logic                beat_err,
    output logic                beat_mismatch,
    output logic [OUTS_W-1:0]   outstanding
);

    logic [7:0]         beats_left [TAG_NUM];
    logic [TAG_NUM-1:0] err_sticky;
    logic               final_beat;
    logic               retire;

    assign beat_hit      = beat_en & active[beat_tag];
    assign final_beat    = (beats_left[beat_tag] == 8'd1);
    assign retire        = beat_hit & (beat_last | final_beat);
    assign beat_err      = err_sticky[beat_tag] | beat_bad;
    assign beat_mismatch = beat_hit & (beat_last != final_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= '0;
            err_sticky <= '0;
            for (int i = 0; i < TAG_NUM; i++) beats_left[i] <= 8'd0;
        end else begin
            if (set_en) begin
                active[set_tag]     <= 1'b1;
                beats_left[set_tag] <= {4'd0, set_len} + 8'd1;
                err_sticky[set_tag] <= 1'b0;
            end
            if (beat_hit) begin
                beats_left[beat_tag] <= beats_left[beat_tag] - 8'd1;
                err_sticky[beat_tag] <= beat_err;
                if (retire) active[beat_tag] <= 1'b0;
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < TAG_NUM; i++) outstanding = outstanding + OUTS_W'(active[i]);
    end

endmodule

// File: rtl/apb2axi_read_builder.sv
// AXI3 read initiator: pops tagged read commands into AR bursts and returns tagged R beats
// to the read-data FIFO through a single-entry output register.
module apb2axi_read_builder
    import apb2axi_pkg::*;
(
    input  logic                   aclk,
    input  logic                   areset,
    output logic [AXI_ID_W-1:0]    arid,
    output logic [AXI_ADDR_W-1:0]  araddr,
    output logic [3:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arlock,
    output logic [3:0]             arcache,
    output logic [2:0]             arprot,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [AXI_ID_W-1:0]    rid,
    input  logic [AXI_DATA_W-1:0]  rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic                   rd_pop_vld,
    output logic                   rd_pop_rdy,
    input  logic [CMD_ENTRY_W-1:0] rd_pop_data,
    output logic                   rdf_push_vld,
    input  logic                   rdf_push_rdy,
    output logic [RD_ENTRY_W-1:0]  rdf_push_data,
    output logic                   err_unexp_id,
    output logic                   err_last_mismatch,
    output logic [OUTS_W-1:0]      rd_outstanding
);

    directory_entry_t   cmd;
    rd_entry_t          push_q;
    logic [TAG_NUM-1:0] active;
    logic               pop;
    logic               r_acc;
    logic               beat_hit;
    logic               beat_err;
    logic               beat_mismatch;

    assign cmd     = rd_pop_data;
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'b0011;
    assign arprot  = 3'b000;

    // The head stalls while its tag is in flight; later commands never overtake it.
    assign rd_pop_rdy = (!arvalid | arready) & !active[cmd.tag] & !areset;
    assign pop        = rd_pop_vld & rd_pop_rdy;
    assign rready     = (!rdf_push_vld | rdf_push_rdy) & !areset;
    assign r_acc      = rvalid & rready;

    apb2axi_rd_tag_tracker u_tracker (
        .clk           (aclk),
        .rst           (areset),
        .set_en        (pop),
        .set_tag       (cmd.tag),
        .set_len       (cmd.len),
        .beat_en       (r_acc),
        .beat_tag      (rid),
        .beat_bad      (rresp != AXI_RESP_OKAY),
        .beat_last     (rlast),
        .active        (active),
        .beat_hit      (beat_hit),
        .beat_err      (beat_err),
        .beat_mismatch (beat_mismatch),
        .outstanding   (rd_outstanding)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
        end else if (pop) begin
            arvalid <= 1'b1;
            arid    <= cmd.tag;
            araddr  <= cmd.addr;
            arlen   <= cmd.len;
            arsize  <= cmd.size;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdf_push_vld      <= 1'b0;
            push_q            <= '0;
            err_unexp_id      <= 1'b0;
            err_last_mismatch <= 1'b0;
        end else begin
            err_unexp_id      <= r_acc & !beat_hit;
            err_last_mismatch <= beat_mismatch;
            if (beat_hit) begin
                rdf_push_vld <= 1'b1;
                push_q       <= '{tag: rid, data: rdata, resp: rresp, last: rlast, err: beat_err};
            end else if (rdf_push_rdy) begin
                rdf_push_vld <= 1'b0;
            end
        end
    end

    assign rdf_push_data = push_q;

endmodule

// File: tb/tb_apb2axi_read_builder.sv
// Directed bench for apb2axi_read_builder: AR issue, interleaved R beats, busy tags,
// back-pressure, error flags and mid-burst reset.
module tb_apb2axi_read_builder;
    import apb2axi_pkg::*;

    logic                   aclk = 1'b0;
    logic                   areset;
    logic [AXI_ID_W-1:0]    arid;
    logic [AXI_ADDR_W-1:0]  araddr;
    logic [3:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arlock;
    logic [3:0]             arcache;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [AXI_ID_W-1:0]    rid;
    logic [AXI_DATA_W-1:0]  rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;
    logic                   rd_pop_vld;
    logic                   rd_pop_rdy;
    logic [CMD_ENTRY_W-1:0] rd_pop_data;
    logic                   rdf_push_vld;
    logic                   rdf_push_rdy;
    logic [RD_ENTRY_W-1:0]  rdf_push_data;
    logic                   err_unexp_id;
    logic                   err_last_mismatch;
    logic [OUTS_W-1:0]      rd_outstanding;

    int vectors = 0;
    int miscompares = 0;
    int unexp_cnt = 0;
    int mism_cnt = 0;
    rd_entry_t pq[$];
    logic [AXI_ID_W-1:0] arq[$];

    always #5 aclk = ~aclk;

    apb2axi_read_builder dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rd_pop_vld(rd_pop_vld), .rd_pop_rdy(rd_pop_rdy), .rd_pop_data(rd_pop_data),
        .rdf_push_vld(rdf_push_vld), .rdf_push_rdy(rdf_push_rdy), .rdf_push_data(rdf_push_data),
        .err_unexp_id(err_unexp_id), .err_last_mismatch(err_last_mismatch),
        .rd_outstanding(rd_outstanding)
    );

    always @(posedge aclk) begin
        if (!areset) begin
            if (rdf_push_vld && rdf_push_rdy) pq.push_back(rd_entry_t'(rdf_push_data));
            if (arvalid && arready) arq.push_back(arid);
            if (err_unexp_id) unexp_cnt++;
            if (err_last_mismatch) mism_cnt++;
        end
    end

    task automatic issue(input logic [3:0] tag, input logic [31:0] addr, input logic [3:0] len);
        directory_entry_t c;
        c.tag = tag; c.addr = addr; c.len = len; c.size = 3'd2;
        rd_pop_data = c;
        rd_pop_vld = 1'b1;
        #1;
        for (int n = 0; n < 100 && !rd_pop_rdy; n++) begin @(negedge aclk); #1; end
        if (!rd_pop_rdy) begin
            vectors++; miscompares++;
            $display("FAIL issue_timeout tag=%0d rd_pop_rdy never rose", tag);
        end
        @(negedge aclk);
        rd_pop_vld = 1'b0;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
        rid = id; rdata = d; rresp = resp; rlast = last; rvalid = 1'b1;
        #1;
        for (int n = 0; n < 100 && !rready; n++) begin @(negedge aclk); #1; end
        if (!rready) begin
            vectors++; miscompares++;
            $display("FAIL rbeat_timeout id=%0d rready never rose", id);
        end
        @(negedge aclk);
        rvalid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid got=%b want=0", arvalid); end
        vectors++; if (rdf_push_vld !== 1'b0) begin miscompares++; $display("FAIL rst_push_vld got=%b want=0", rdf_push_vld); end
        vectors++; if (rd_outstanding !== '0) begin miscompares++; $display("FAIL rst_outstanding got=%0d want=0", rd_outstanding); end
        vectors++; if (rready !== 1'b0 || rd_pop_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_rdy got rready=%b pop_rdy=%b want 0,0", rready, rd_pop_rdy); end
        vectors++; if (err_unexp_id !== 1'b0 || err_last_mismatch !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b%b want=00", err_unexp_id, err_last_mismatch); end
        vectors++; if ({arburst, arlock, arcache, arprot} !== {2'b01, 1'b0, 4'b0011, 3'b000}) begin
            miscompares++; $display("FAIL rst_ar_const got burst=%b lock=%b cache=%b prot=%b want 01 0 0011 000", arburst, arlock, arcache, arprot);
        end
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_single();
        pq.delete();
        arready = 1'b0;
        issue(4'd2, 32'h1000, 4'd3);
        #1;
        vectors++; if ({arvalid, arid, araddr, arlen, arsize} !== {1'b1, 4'd2, 32'h1000, 4'd3, 3'd2}) begin
            miscompares++; $display("FAIL single_ar got v=%b id=%0d addr=%h len=%0d size=%0d want 1 2 1000 3 2", arvalid, arid, araddr, arlen, arsize);
        end
        vectors++; if (rd_outstanding !== 5'd1) begin miscompares++; $display("FAIL single_outs_1 got=%0d want=1", rd_outstanding); end
        @(negedge aclk); #1;
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h1000) begin miscompares++; $display("FAIL single_ar_hold got v=%b addr=%h want 1 1000", arvalid, araddr); end
        arready = 1'b1;
        @(negedge aclk); #1;
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL single_ar_drop got=%b want=0", arvalid); end
        for (int i = 0; i < 4; i++) r_beat(4'd2, 32'hA0 + i, AXI_RESP_OKAY, i == 3);
        repeat (2) @(negedge aclk); #1;
        vectors++; if (pq.size() != 4) begin miscompares++; $display("FAIL single_push_cnt got=%0d want=4", pq.size()); end
        for (int i = 0; i < 4 && i < pq.size(); i++) begin
            vectors++; if (pq[i] !== '{tag: 4'd2, data: 32'hA0 + i, resp: 2'b00, last: (i == 3), err: 1'b0}) begin
                miscompares++; $display("FAIL single_beat%0d got=%h want tag2 data=%h last=%0d", i, pq[i], 32'hA0 + i, i == 3);
            end
        end
        vectors++; if (rd_outstanding !== 5'd0) begin miscompares++; $display("FAIL single_outs_0 got=%0d want=0", rd_outstanding); end
    endtask

    task automatic test_interleave();
        logic [3:0] ord [5] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
        logic       lst [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int u0, m0;
        pq.delete(); arq.delete();
        u0 = unexp_cnt; m0 = mism_cnt;
        issue(4'd0, 32'h2000, 4'd1);
        issue(4'd1, 32'h3000, 4'd2);
        #1;
        vectors++; if (rd_outstanding !== 5'd2) begin miscompares++; $display("FAIL il_outs_2 got=%0d want=2", rd_outstanding); end
        for (int i = 0; i < 5; i++) r_beat(ord[i], 32'h100 + i, AXI_RESP_OKAY, lst[i]);
        repeat (2) @(negedge aclk); #1;
        vectors++; if (arq.size() != 2 || arq[0] !== 4'd0 || arq[1] !== 4'd1) begin miscompares++; $display("FAIL il_ar_order got n=%0d want ids 0,1", arq.size()); end
        vectors++; if (pq.size() != 5) begin miscompares++; $display("FAIL il_push_cnt got=%0d want=5", pq.size()); end
        for (int i = 0; i < 5 && i < pq.size(); i++) begin
            vectors++; if (pq[i].tag !== ord[i] || pq[i].data !== 32'h100 + i || pq[i].last !== lst[i] || pq[i].err !== 1'b0) begin
                miscompares++; $display("FAIL il_beat%0d got=%h want tag=%0d data=%h last=%b", i, pq[i], ord[i], 32'h100 + i, lst[i]);
            end
        end
        vectors++; if (rd_outstanding !== 5'd0 || unexp_cnt != u0 || mism_cnt != m0) begin
            miscompares++; $display("FAIL il_clean got outs=%0d unexp+%0d mism+%0d want 0 0 0", rd_outstanding, unexp_cnt - u0, mism_cnt - m0);
        end
    endtask

    task automatic test_busy();
        directory_entry_t c;
        int held;
        pq.delete();
        issue(4'd3, 32'h4000, 4'd2);
        c.tag = 4'd3; c.addr = 32'h5000; c.len = 4'd0; c.size = 3'd2;
        rd_pop_data = c; rd_pop_vld = 1'b1;
        held = 0;
        for (int i = 0; i < 3; i++) begin
            rid = 4'd3; rdata = 32'hB0 + i; rresp = AXI_RESP_OKAY; rlast = (i == 2); rvalid = 1'b1;
            #1;
            if (rd_pop_rdy === 1'b0) held++;
            @(negedge aclk);
        end
        rvalid = 1'b0;
        vectors++; if (held != 3) begin miscompares++; $display("FAIL busy_held got=%0d cycles stalled want=3", held); end
        #1;
        vectors++; if (rd_pop_rdy !== 1'b1) begin miscompares++; $display("FAIL busy_release got=%b want=1", rd_pop_rdy); end
        @(negedge aclk);
        rd_pop_vld = 1'b0;
        #1;
        vectors++; if (arvalid !== 1'b1 || arid !== 4'd3 || araddr !== 32'h5000) begin
            miscompares++; $display("FAIL busy_reissue got v=%b id=%0d addr=%h want 1 3 5000", arvalid, arid, araddr);
        end
        @(negedge aclk);
        r_beat(4'd3, 32'hB3, AXI_RESP_OKAY, 1'b1);
        repeat (2) @(negedge aclk); #1;
        vectors++; if (pq.size() != 4 || rd_outstanding !== 5'd0) begin miscompares++; $display("FAIL busy_done got pushes=%0d outs=%0d want 4 0", pq.size(), rd_outstanding); end
    endtask

    task automatic test_backpressure();
        int stalled;
        pq.delete();
        issue(4'd4, 32'h6000, 4'd3);
        r_beat(4'd4, 32'hC0, AXI_RESP_OKAY, 1'b0);
        rdf_push_rdy = 1'b0;
        rid = 4'd4; rdata = 32'hC1; rresp = AXI_RESP_OKAY; rlast = 1'b0; rvalid = 1'b1;
        stalled = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rready === 1'b0 && rdf_push_vld === 1'b1) stalled++;
            @(negedge aclk);
        end
        vectors++; if (stalled != 5) begin miscompares++; $display("FAIL bp_rready got %0d stalled cycles want=5", stalled); end
        rdf_push_rdy = 1'b1;
        r_beat(4'd4, 32'hC1, AXI_RESP_OKAY, 1'b0);
        r_beat(4'd4, 32'hC2, AXI_RESP_OKAY, 1'b0);
        r_beat(4'd4, 32'hC3, AXI_RESP_OKAY, 1'b1);
        repeat (2) @(negedge aclk); #1;
        vectors++; if (pq.size() != 4) begin miscompares++; $display("FAIL bp_push_cnt got=%0d want=4", pq.size()); end
        for (int i = 0; i < 4 && i < pq.size(); i++) begin
            vectors++; if (pq[i].data !== 32'hC0 + i || pq[i].tag !== 4'd4) begin
                miscompares++; $display("FAIL bp_beat%0d got data=%h tag=%0d want data=%h tag=4", i, pq[i].data, pq[i].tag, 32'hC0 + i);
            end
        end
    endtask

    task automatic test_errors();
        int u0, m0;
        pq.delete();
        issue(4'd6, 32'h7000, 4'd2);
        r_beat(4'd6, 32'hD0, AXI_RESP_SLVERR, 1'b0);
        r_beat(4'd6, 32'hD1, AXI_RESP_OKAY, 1'b0);
        r_beat(4'd6, 32'hD2, AXI_RESP_OKAY, 1'b1);
        repeat (2) @(negedge aclk); #1;
        vectors++; if (pq.size() != 3) begin miscompares++; $display("FAIL err_push_cnt got=%0d want=3", pq.size()); end
        for (int i = 0; i < 3 && i < pq.size(); i++) begin
            vectors++; if (pq[i].err !== 1'b1) begin miscompares++; $display("FAIL err_sticky_beat%0d got err=%b want=1", i, pq[i].err); end
        end
        vectors++; if (pq.size() > 0 && pq[0].resp !== AXI_RESP_SLVERR) begin miscompares++; $display("FAIL err_resp got=%b want=10", pq[0].resp); end

        pq.delete();
        m0 = mism_cnt;
        issue(4'd7, 32'h7100, 4'd2);
        r_beat(4'd7, 32'hE0, AXI_RESP_OKAY, 1'b0);
        r_beat(4'd7, 32'hE1, AXI_RESP_OKAY, 1'b1);
        repeat (2) @(negedge aclk); #1;
        vectors++; if (mism_cnt - m0 != 1) begin miscompares++; $display("FAIL err_mismatch got %0d pulses want=1", mism_cnt - m0); end
        vectors++; if (pq.size() != 2 || rd_outstanding !== 5'd0) begin miscompares++; $display("FAIL err_early_retire got pushes=%0d outs=%0d want 2 0", pq.size(), rd_outstanding); end

        pq.delete();
        u0 = unexp_cnt;
        r_beat(4'd5, 32'hF0, AXI_RESP_OKAY, 1'b1);
        repeat (2) @(negedge aclk); #1;
        vectors++; if (unexp_cnt - u0 != 1 || pq.size() != 0) begin
            miscompares++; $display("FAIL err_unexp got pulses=%0d pushes=%0d want 1 0", unexp_cnt - u0, pq.size());
        end
    endtask

    task automatic test_reset_mid();
        int u0;
        issue(4'd8, 32'h8000, 4'd7);
        r_beat(4'd8, 32'h90, AXI_RESP_OKAY, 1'b0);
        r_beat(4'd8, 32'h91, AXI_RESP_OKAY, 1'b0);
        #2 areset = 1'b1;
        #1;
        vectors++; if (rdf_push_vld !== 1'b0 || arvalid !== 1'b0 || rd_outstanding !== '0) begin
            miscompares++; $display("FAIL rmid_async got push_vld=%b arvalid=%b outs=%0d want 0 0 0", rdf_push_vld, arvalid, rd_outstanding);
        end
        @(negedge aclk);
        areset = 1'b0;
        pq.delete();
        u0 = unexp_cnt;
        r_beat(4'd8, 32'h92, AXI_RESP_OKAY, 1'b0);
        repeat (2) @(negedge aclk); #1;
        vectors++; if (unexp_cnt - u0 != 1 || pq.size() != 0) begin
            miscompares++; $display("FAIL rmid_stale got pulses=%0d pushes=%0d want 1 0", unexp_cnt - u0, pq.size());
        end
    endtask

    initial begin
        areset = 1'b1; arready = 1'b1; rdf_push_rdy = 1'b1;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        rd_pop_vld = 1'b0; rd_pop_data = '0;
        test_reset();
        test_single();
        test_interleave();
        test_busy();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
